// File: rtl/clahe_axi_pkg.sv
// Shared constants for the VGA-timing to AXI4-Stream output bridge.
package clahe_axi_pkg;

    // TLAST generation modes
    localparam int AXIS_LAST_COUNT = 0;  // TLAST from column count vs programmed width
    localparam int AXIS_LAST_EDGE  = 1;  // TLAST on the last pixel before DATA_EN falls

    localparam int WIDTH_W     = 11;
    localparam int FRAME_CNT_W = 16;

    // True when the pixel at column col is the final one of a width-pixel line
    function automatic logic col_is_last(input logic [WIDTH_W-1:0] col,
                                         input logic [WIDTH_W-1:0] width);
        return col == (width - WIDTH_W'(1));
    endfunction

endpackage

// File: rtl/axis_fwft_fifo.sv
// First-word-fall-through FIFO: the head word is visible on dout whenever
// empty is low. Read is asynchronous so the head is available in the same
// cycle it is written, which keeps the bridge latency at two cycles.
module axis_fwft_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      used;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign used  = wr_ptr_reg - rd_ptr_reg;
    assign full  = used[AW];
    assign empty = (used == '0);
    assign free  = (AW+1)'(DEPTH) - used;

    // A push into a full FIFO is still accepted when a pop frees the slot this cycle
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign dout = mem[rd_ptr_reg[AW-1:0]];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Read/write pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/vga_to_axis_bridge.sv
// Converts an HSYNC/VSYNC/DATA_EN pixel stream into an AXI4-Stream master
// with TUSER marking start of frame and TLAST marking end of line. A one-pixel
// hold stage lets TLAST be decided from the following cycle, and an elastic
// FWFT FIFO absorbs sink backpressure.
module vga_to_axis_bridge
    import clahe_axi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 1,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_MARGIN  = 8,
    parameter int LAST_MODE  = AXIS_LAST_COUNT
) (
    input  logic                          ACLK,
    input  logic                          ARESTN,
    input  logic                          H_SYNC,
    input  logic                          V_SYNC,
    input  logic                          DATA_EN,
    input  logic [DATA_W*CHANNELS-1:0]    pixel,
    input  logic [WIDTH_W-1:0]            width_in,
    input  logic                          enable,
    input  logic                          err_clr,
    output logic                          src_ready,
    output logic [DATA_W*CHANNELS-1:0]    TDATA,
    output logic                          TSTRB,
    output logic                          TLAST,
    output logic                          TUSER,
    output logic                          TVALID,
    input  logic                          TREADY,
    output logic                          overflow,
    output logic                          line_err,
    output logic [FRAME_CNT_W-1:0]        frame_cnt
);
    localparam int PW = DATA_W * CHANNELS;
    localparam int FW = PW + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] AF_LIM = (AW+1)'(AF_MARGIN);

    // H_SYNC travels with the stream for alignment only; framing ignores it
    logic unused_hsync;
    assign unused_hsync = H_SYNC;

    // Frame/line tracking state
    logic               vs_d_reg, de_d_reg;
    logic [WIDTH_W-1:0] width_reg, col_reg, col_next;
    logic               en_reg, edge_mode_reg, sof_arm_reg, sof_arm_next;

    // Hold stage: one captured pixel waiting for its TLAST decision
    logic               hold_valid_reg, hold_sof_reg, hold_last_reg, hold_edge_reg;
    logic [PW-1:0]      hold_data_reg;

    logic               overflow_reg, line_err_reg, src_ready_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;

    logic               vs_rise, de_fall, capture, cap_last;
    logic               en_eff, edge_eff, sof_eff;
    logic [WIDTH_W-1:0] width_eff, col_eff;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, tvalid;
    logic [FW-1:0]      fifo_din, fifo_dout;
    logic [AW:0]        fifo_free;
    logic               ovf_set, lerr_set;

    // A V_SYNC rise takes effect in its own cycle so a coincident pixel is the SOF pixel
    assign vs_rise   = V_SYNC && !vs_d_reg;
    assign de_fall   = de_d_reg && !DATA_EN;
    assign width_eff = vs_rise ? width_in : width_reg;
    assign en_eff    = vs_rise ? enable : en_reg;
    assign edge_eff  = vs_rise ? ((LAST_MODE == AXIS_LAST_EDGE) || (width_in == '0))
                               : edge_mode_reg;
    assign sof_eff   = vs_rise || sof_arm_reg;
    assign col_eff   = vs_rise ? '0 : col_reg;
    assign capture   = DATA_EN && en_eff;

    // Column counter and count-mode TLAST tag; col stays 0 in edge mode
    always_comb begin
        col_next     = col_eff;
        cap_last     = 1'b0;
        sof_arm_next = capture ? 1'b0 : sof_eff;
        if (capture && !edge_eff) begin
            if (col_is_last(col_eff, width_eff)) begin
                cap_last = 1'b1;
                col_next = '0;
            end else begin
                col_next = col_eff + WIDTH_W'(1);
            end
        end else if (de_fall) begin
            col_next = '0;
        end
    end

    // A line that stops short of width_in leaves a non-zero column behind
    assign lerr_set = de_fall && (col_reg != '0);

    // Frame latches, sync edge detectors and column state
    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            vs_d_reg      <= 1'b1;  // a V_SYNC already high at reset release is not a frame start
            de_d_reg      <= 1'b0;
            width_reg     <= '0;
            en_reg        <= 1'b0;
            edge_mode_reg <= 1'b0;
            sof_arm_reg   <= 1'b0;
            col_reg       <= '0;
        end else begin
            vs_d_reg    <= V_SYNC;
            de_d_reg    <= DATA_EN;
            sof_arm_reg <= sof_arm_next;
            col_reg     <= col_next;
            if (vs_rise) begin
                width_reg     <= width_in;
                en_reg        <= enable;
                edge_mode_reg <= edge_eff;
            end
        end
    end

    // Hold stage capture; the held pixel always moves to the FIFO next cycle
    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            hold_valid_reg <= 1'b0;
            hold_sof_reg   <= 1'b0;
            hold_last_reg  <= 1'b0;
            hold_edge_reg  <= 1'b0;
            hold_data_reg  <= '0;
        end else begin
            hold_valid_reg <= capture;
            if (capture) begin
                hold_sof_reg  <= sof_eff;
                hold_last_reg <= cap_last;
                hold_edge_reg <= edge_eff;
                hold_data_reg <= pixel;
            end
        end
    end

    // In edge mode the held pixel closes the line when DATA_EN is now low
    assign fifo_push = hold_valid_reg;
    assign fifo_din  = {hold_sof_reg, hold_edge_reg ? !DATA_EN : hold_last_reg, hold_data_reg};
    assign fifo_pop  = tvalid && TREADY;
    assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

    axis_fwft_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESTN),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    // Sticky flags (a new error beats err_clr), frame counter and throttle hint
    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            overflow_reg  <= 1'b0;
            line_err_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            src_ready_reg <= 1'b1;
        end else begin
            overflow_reg  <= ovf_set  || (overflow_reg && !err_clr);
            line_err_reg  <= lerr_set || (line_err_reg && !err_clr);
            src_ready_reg <= (fifo_free > AF_LIM);
            if (fifo_pop && fifo_dout[PW+1]) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
            end
        end
    end

    assign tvalid    = !fifo_empty;
    assign TVALID    = tvalid;
    assign TSTRB     = tvalid;
    assign TLAST     = tvalid && fifo_dout[PW];
    assign TUSER     = tvalid && fifo_dout[PW+1];
    assign overflow  = overflow_reg;
    assign line_err  = line_err_reg;
    assign frame_cnt = frame_cnt_reg;
    assign src_ready = src_ready_reg;

    // Drive TDATA to zero between beats so idle cycles never show stale words
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign TDATA[gi*DATA_W +: DATA_W] = fifo_dout[gi*DATA_W +: DATA_W] & {DATA_W{tvalid}};
    end

endmodule
